// File: rtl/tilelink_ram_pkg.sv
// TileLink-UL channel types and shared constants for the tilelink_ram responder.
package TL;

  localparam int AddrW   = 32;
  localparam int DataW   = 32;
  localparam int MaskW   = DataW / 8;
  localparam int SizeW   = 3;
  localparam int SourceW = 8;
  localparam int SinkW   = 1;

  // Largest legal beat: 2^MaxSize bytes, one full data word.
  localparam int MaxSize = 2;
  localparam int SinkId  = 0;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } a_opcode_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_opcode_e;

  typedef struct packed {
    logic               a_valid;
    a_opcode_e          a_opcode;
    logic [2:0]         a_param;
    logic [SizeW-1:0]   a_size;
    logic [SourceW-1:0] a_source;
    logic [AddrW-1:0]   a_address;
    logic [MaskW-1:0]   a_mask;
    logic [DataW-1:0]   a_data;
    logic               a_ready;
  } tilelink_a;

  typedef struct packed {
    logic               d_valid;
    d_opcode_e          d_opcode;
    logic [1:0]         d_param;
    logic [SizeW-1:0]   d_size;
    logic [SourceW-1:0] d_source;
    logic [SinkW-1:0]   d_sink;
    logic [DataW-1:0]   d_data;
    logic               d_error;
    logic               d_ready;
  } tilelink_d;

  function automatic logic [DataW-1:0] expand_bitmask(input logic [MaskW-1:0] mask);
    logic [DataW-1:0] lanes;
    lanes = '0;
    for (int i = 0; i < MaskW; i++) begin
      lanes[8*i +: 8] = {8{mask[i]}};
    end
    return lanes;
  endfunction

endpackage

// File: rtl/tilelink_ram_mem.sv
// Single-port WORDS x 32-bit RAM with byte-lane write enable and registered read.
module tilelink_ram_mem
  import TL::*;
#(
  parameter  int WORDS = 1024,
  localparam int IdxW  = $clog2(WORDS)
) (
  input  logic             clock,
  input  logic [IdxW-1:0]  addr,
  input  logic [MaskW-1:0] we,
  input  logic [DataW-1:0] wdata,
  input  logic             re,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [WORDS];
  logic [DataW-1:0] lanes;

  assign lanes = expand_bitmask(we);

  // NOTE: the array and read register carry no reset so the tools can map them onto RAM macros.
  always_ff @(posedge clock) begin
    if (|we) begin
      mem[addr] <= (mem[addr] & ~lanes) | (wdata & lanes);
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tilelink_ram.sv
// TileLink-UL RAM responder: A-channel decode, error checks, one-entry D response register.
// Optional feature macro: TILELINK_RAM_PARTIAL_EN enables PutPartialData writes.
module tilelink_ram
  import TL::*;
#(
  parameter int          WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic      clock,
  input  logic      reset,
  input  tilelink_a tl_a,
  output logic      a_ready,
  output tilelink_d tl_d,
  input  logic      d_ready
);

  localparam int IdxW  = $clog2(WORDS);
  localparam int SpanW = IdxW + 2;

`ifdef TILELINK_RAM_PARTIAL_EN
  localparam bit PartialEn = 1'b1;
`else
  localparam bit PartialEn = 1'b0;
`endif

  typedef enum logic {EMPTY, FULL} state_e;

  state_e state_q, state_d;
  logic   a_fire, d_fire;

  assign a_ready = !reset && (state_q == EMPTY || d_ready);
  assign a_fire  = tl_a.a_valid && a_ready;
  assign d_fire  = (state_q == FULL) && d_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: assign every always_comb output a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (a_fire) state_d = FULL;
      FULL: begin
        if (a_fire)      state_d = FULL;
        else if (d_fire) state_d = EMPTY;
      end
    endcase
  end

  logic [AddrW-1:0] off;
  logic [IdxW-1:0]  idx;
  logic             range_err, align_err, op_err, err;
  logic             is_get, is_put_full, is_put_partial;

  assign off = tl_a.a_address - BASE_ADDR;
  assign idx = off[2 +: IdxW];
  assign range_err = (off >> SpanW) != '0;

  always_comb begin
    align_err = 1'b0;
    if (tl_a.a_size > SizeW'(MaxSize))                         align_err = 1'b1;
    else if (tl_a.a_size == 3'd2 && tl_a.a_address[1:0] != 2'b00) align_err = 1'b1;
    else if (tl_a.a_size == 3'd1 && tl_a.a_address[0])            align_err = 1'b1;
  end

  always_comb begin
    is_get         = 1'b0;
    is_put_full    = 1'b0;
    is_put_partial = 1'b0;
    op_err         = 1'b0;
    unique case (tl_a.a_opcode)
      Get:            is_get         = 1'b1;
      PutFullData:    is_put_full    = 1'b1;
      PutPartialData: is_put_partial = 1'b1;
      default:        op_err         = 1'b1;
    endcase
  end

  // Without partial-write support PutPartialData is reported as an error, never written.
  assign err = range_err || align_err || op_err || (is_put_partial && !PartialEn);

  logic [MaskW-1:0] mem_we;
  logic             mem_re;
  logic [DataW-1:0] mem_rdata;

  assign mem_we = (a_fire && !err && (is_put_full || is_put_partial)) ? tl_a.a_mask : '0;
  assign mem_re = a_fire && !err && is_get;

  tilelink_ram_mem #(.WORDS(WORDS)) u_mem (
    .clock (clock),
    .addr  (idx),
    .we    (mem_we),
    .wdata (tl_a.a_data),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  d_opcode_e          rsp_opcode;
  logic               rsp_error;
  logic [SizeW-1:0]   rsp_size;
  logic [SourceW-1:0] rsp_source;
  logic               rsp_data_sel;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_opcode   <= AccessAck;
      rsp_error    <= 1'b0;
      rsp_size     <= '0;
      rsp_source   <= '0;
      rsp_data_sel <= 1'b0;
    end else if (a_fire) begin
      rsp_opcode   <= is_get ? AccessAckData : AccessAck;
      rsp_error    <= err;
      rsp_size     <= tl_a.a_size;
      rsp_source   <= tl_a.a_source;
      rsp_data_sel <= mem_re;
    end
  end

  // The RAM read register only loads on an accepted Get, so a stalled response stays stable.
  always_comb begin
    tl_d          = '0;
    tl_d.d_valid  = (state_q == FULL);
    tl_d.d_opcode = rsp_opcode;
    tl_d.d_param  = '0;
    tl_d.d_size   = rsp_size;
    tl_d.d_source = rsp_source;
    tl_d.d_sink   = SinkW'(SinkId);
    tl_d.d_data   = rsp_data_sel ? mem_rdata : '0;
    tl_d.d_error  = rsp_error;
    tl_d.d_ready  = 1'b0;
  end

  logic unused_ok;
  assign unused_ok = ^{tl_a.a_param, tl_a.a_ready, off[1:0]};

endmodule

// File: tb/tb_tilelink_ram.sv
// Directed, table-driven bench for tilelink_ram plus stall and reset sequences.
module tb_tilelink_ram;
  import TL::*;

  logic      clock;
  logic      reset;
  tilelink_a tl_a;
  logic      a_ready;
  tilelink_d tl_d;
  logic      d_ready;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef TILELINK_RAM_PARTIAL_EN
  localparam logic        PARTIAL_ERR = 1'b0;
  localparam logic [31:0] EXP_10      = 32'hDEAD_BE11;
`else
  localparam logic        PARTIAL_ERR = 1'b1;
  localparam logic [31:0] EXP_10      = 32'hDEAD_BEEF;
`endif

  tilelink_ram #(.WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
    .clock   (clock),
    .reset   (reset),
    .tl_a    (tl_a),
    .a_ready (a_ready),
    .tl_d    (tl_d),
    .d_ready (d_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    a_opcode_e   op;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  src;
    d_opcode_e   eop;
    logic        eerr;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input a_opcode_e op, input logic [31:0] addr,
                              input logic [2:0] size, input logic [3:0] mask, input logic [31:0] data,
                              input logic [7:0] src, input d_opcode_e eop, input logic eerr,
                              input logic [31:0] edata);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.size = size; v.mask = mask; v.data = data;
    v.src = src; v.eop = eop; v.eerr = eerr; v.edata = edata;
    return v;
  endfunction

  task automatic drive_a(input vec_t v);
    tl_a           = '0;
    tl_a.a_valid   = 1'b1;
    tl_a.a_opcode  = v.op;
    tl_a.a_size    = v.size;
    tl_a.a_source  = v.src;
    tl_a.a_address = v.addr;
    tl_a.a_mask    = v.mask;
    tl_a.a_data    = v.data;
  endtask

  // Called at a negedge; returns at the negedge after the response appears.
  task automatic send(input vec_t v);
    int n;
    drive_a(v);
    d_ready = 1'b1;
    n = 0;
    while (!a_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({v.name, " a_ready timeout"}, 32'(a_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    tl_a.a_valid = 1'b0;
    check({v.name, " d_valid"},  32'(tl_d.d_valid),  32'd1);
    check({v.name, " d_opcode"}, 32'(tl_d.d_opcode), 32'(v.eop));
    check({v.name, " d_error"},  32'(tl_d.d_error),  32'(v.eerr));
    check({v.name, " d_data"},   tl_d.d_data,        v.edata);
    check({v.name, " d_source"}, 32'(tl_d.d_source), 32'(v.src));
    check({v.name, " d_size"},   32'(tl_d.d_size),   32'(v.size));
  endtask

  initial begin
    vec_t g;

    vecs.push_back(mk("put 0x10",        PutFullData,    32'h10,   3'd2, 4'hF, 32'hDEADBEEF, 8'd1,  AccessAck,     1'b0,        32'h0));
    vecs.push_back(mk("get 0x10",        Get,            32'h10,   3'd2, 4'hF, 32'h0,        8'd2,  AccessAckData, 1'b0,        32'hDEADBEEF));
    vecs.push_back(mk("partial 0x10",    PutPartialData, 32'h10,   3'd2, 4'h1, 32'h00000011, 8'd3,  AccessAck,     PARTIAL_ERR, 32'h0));
    vecs.push_back(mk("get after part",  Get,            32'h10,   3'd2, 4'hF, 32'h0,        8'd4,  AccessAckData, 1'b0,        EXP_10));
    vecs.push_back(mk("get range",       Get,            32'h1000, 3'd2, 4'hF, 32'h0,        8'd5,  AccessAckData, 1'b1,        32'h0));
    vecs.push_back(mk("get misalign",    Get,            32'h12,   3'd2, 4'hF, 32'h0,        8'd6,  AccessAckData, 1'b1,        32'h0));
    vecs.push_back(mk("arith op",        ArithmeticData, 32'h10,   3'd2, 4'hF, 32'h0,        8'd7,  AccessAck,     1'b1,        32'h0));
    vecs.push_back(mk("get after arith", Get,            32'h10,   3'd2, 4'hF, 32'h0,        8'd8,  AccessAckData, 1'b0,        EXP_10));
    vecs.push_back(mk("put 0x20",        PutFullData,    32'h20,   3'd2, 4'hF, 32'h12345678, 8'd9,  AccessAck,     1'b0,        32'h0));
    vecs.push_back(mk("put half 0x22",   PutFullData,    32'h22,   3'd1, 4'hC, 32'hABCD0000, 8'd10, AccessAck,     1'b0,        32'h0));
    vecs.push_back(mk("get 0x20",        Get,            32'h20,   3'd2, 4'hF, 32'h0,        8'd11, AccessAckData, 1'b0,        32'hABCD5678));
    vecs.push_back(mk("put half odd",    PutFullData,    32'h21,   3'd1, 4'h2, 32'hFFFFFFFF, 8'd12, AccessAck,     1'b1,        32'h0));
    vecs.push_back(mk("get size3",       Get,            32'h20,   3'd3, 4'hF, 32'h0,        8'd13, AccessAckData, 1'b1,        32'h0));
    vecs.push_back(mk("get 0x20 again",  Get,            32'h20,   3'd2, 4'hF, 32'h0,        8'd14, AccessAckData, 1'b0,        32'hABCD5678));
    vecs.push_back(mk("put last",        PutFullData,    32'hFFC,  3'd2, 4'hF, 32'hCAFEF00D, 8'd15, AccessAck,     1'b0,        32'h0));
    vecs.push_back(mk("get last",        Get,            32'hFFC,  3'd2, 4'hF, 32'h0,        8'd16, AccessAckData, 1'b0,        32'hCAFEF00D));

    // Reset and idle.
    reset   = 1'b1;
    tl_a    = '0;
    d_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset a_ready", 32'(a_ready),     32'd0);
    check("reset d_valid", 32'(tl_d.d_valid), 32'd0);
    check("reset d_data",  tl_d.d_data,      32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("idle a_ready", 32'(a_ready),     32'd1);
    check("idle d_valid", 32'(tl_d.d_valid), 32'd0);

    foreach (vecs[i]) send(vecs[i]);
    @(negedge clock);
    check("drain d_valid", 32'(tl_d.d_valid), 32'd0);

    // Three back-to-back Gets with a three-cycle D stall after the first response.
    g = mk("g1", Get, 32'h10, 3'd2, 4'hF, 32'h0, 8'd21, AccessAckData, 1'b0, EXP_10);
    drive_a(g);
    d_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    tl_a.a_address = 32'h20;
    tl_a.a_source  = 8'd22;
    for (int c = 0; c < 3; c++) begin
      check("stall a_ready",  32'(a_ready),         32'd0);
      check("stall d_valid",  32'(tl_d.d_valid),    32'd1);
      check("stall d_data",   tl_d.d_data,          EXP_10);
      check("stall d_source", 32'(tl_d.d_source),   32'd21);
      @(negedge clock);
    end
    d_ready = 1'b1;
    #1;
    check("unstall a_ready", 32'(a_ready),       32'd1);
    check("r1 d_data",       tl_d.d_data,        EXP_10);
    check("r1 d_source",     32'(tl_d.d_source), 32'd21);
    @(negedge clock);
    tl_a.a_address = 32'hFFC;
    tl_a.a_source  = 8'd23;
    check("r2 d_valid",  32'(tl_d.d_valid),  32'd1);
    check("r2 d_data",   tl_d.d_data,        32'hABCD5678);
    check("r2 d_source", 32'(tl_d.d_source), 32'd22);
    @(negedge clock);
    tl_a.a_valid = 1'b0;
    check("r3 d_valid",  32'(tl_d.d_valid),  32'd1);
    check("r3 d_data",   tl_d.d_data,        32'hCAFEF00D);
    check("r3 d_source", 32'(tl_d.d_source), 32'd23);
    @(negedge clock);
    check("after burst d_valid", 32'(tl_d.d_valid), 32'd0);

    // Reset while a response is pending and stalled; RAM contents survive.
    g = mk("g pend", Get, 32'h20, 3'd2, 4'hF, 32'h0, 8'd30, AccessAckData, 1'b0, 32'hABCD5678);
    drive_a(g);
    d_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    tl_a.a_valid = 1'b0;
    check("pend d_valid", 32'(tl_d.d_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midreset d_valid", 32'(tl_d.d_valid), 32'd0);
    check("midreset d_data",  tl_d.d_data,      32'h0);
    check("midreset a_ready", 32'(a_ready),     32'd0);
    reset = 1'b0;
    @(negedge clock);
    send(mk("get post reset", Get, 32'h20, 3'd2, 4'hF, 32'h0, 8'd31, AccessAckData, 1'b0, 32'hABCD5678));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
